// File: rtl/harvos_mem_pkg.sv
// Shared encodings for the PTW/LSU data-memory arbiter and related D-side blocks.
package harvos_mem_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_RESP  = 3'd3,
        ARB_DRAIN = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_PTW = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int TMO_W = 16;

    // Request fields captured at grant; drives the bus address phase.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/ptw_mem_arbiter_if.sv
// D-side memory bus: one outstanding request, address-phase grant, single-beat response.
interface ptw_mem_arbiter_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/pt_window_check.sv
// Page-table window check: flags PTE addresses outside [base, limit] or not word aligned.
module pt_window_check (
    input  logic [31:0] addr,
    input  logic [31:0] base,
    input  logic [31:0] limit,
    output logic        fault
);
    assign fault = (addr < base) || (addr > limit) || (addr[1:0] != 2'b00);
endmodule

// File: rtl/ptw_mem_arbiter.sv
// Shares the data-memory port between the Sv32 PTW and the LSU, one transaction in flight,
// PTW priority bounded by an LSU starvation counter.
module ptw_mem_arbiter
    import harvos_mem_pkg::*;
#(
    parameter logic [31:0] PT_BASE      = 32'h0010_0000,
    parameter logic [31:0] PT_END       = 32'h001F_FFFF,
    parameter int          STARVE_LIMIT = 8,
    parameter int          TIMEOUT      = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ptw_req,
    input  logic [31:0] ptw_addr,
    output logic [31:0] ptw_rdata,
    output logic        ptw_rvalid,
    output logic        ptw_fault,

    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_we,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    output logic [31:0] lsu_rdata,
    output logic        lsu_rvalid,
    output logic        lsu_err,

    ptw_mem_arbiter_if.master bus
);

    localparam int              SC_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX   = SC_W'(STARVE_LIMIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    mem_req_t        req_q, req_d;
    logic            mem_req_q, mem_req_d;
    logic            ptw_rvalid_q, ptw_rvalid_d, ptw_fault_q, ptw_fault_d;
    logic [31:0]     ptw_rdata_q, ptw_rdata_d;
    logic            lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
    logic [31:0]     lsu_rdata_q, lsu_rdata_d;
    logic [SC_W-1:0] starve_cnt, starve_cnt_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
    logic            win_fault, grant_lsu, grant_ptw;
    logic            rsp_err;
    logic [31:0]     rsp_data;

    pt_window_check u_win (
        .addr  (ptw_addr),
        .base  (PT_BASE),
        .limit (PT_END),
        .fault (win_fault)
    );

    assign grant_lsu = lsu_req && (!ptw_req || starve_cnt == SC_MAX);
    assign grant_ptw = ptw_req && !grant_lsu;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        req_d        = req_q;
        mem_req_d    = 1'b0;
        ptw_rvalid_d = 1'b0;
        ptw_fault_d  = 1'b0;
        ptw_rdata_d  = '0;
        lsu_rvalid_d = 1'b0;
        lsu_err_d    = 1'b0;
        lsu_rdata_d  = '0;
        starve_cnt_d = lsu_req ? starve_cnt : '0;
        tmo_cnt_d    = tmo_cnt;
        rsp_err      = 1'b0;
        rsp_data     = '0;

        case (state_q)
            ARB_IDLE: begin
                if (grant_lsu) begin
                    owner_d      = OWN_LSU;
                    req_d        = '{addr: lsu_addr, we: lsu_we, wdata: lsu_wdata, wstrb: lsu_wstrb};
                    mem_req_d    = 1'b1;
                    starve_cnt_d = '0;
                    state_d      = ARB_ISSUE;
                end else if (grant_ptw) begin
                    owner_d = OWN_PTW;
                    req_d   = '{addr: ptw_addr, we: 1'b0, wdata: '0, wstrb: '0};
                    if (lsu_req && starve_cnt != SC_MAX)
                        starve_cnt_d = starve_cnt + SC_W'(1);
                    // Out-of-window PTEs never reach the bus.
                    if (win_fault) begin
                        ptw_rvalid_d = 1'b1;
                        ptw_fault_d  = 1'b1;
                        state_d      = ARB_RESP;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = ARB_ISSUE;
                    end
                end
            end
            ARB_ISSUE: begin
                if (bus.mem_gnt) begin
                    tmo_cnt_d = '0;
                    state_d   = ARB_WAIT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ARB_WAIT: begin
                if (bus.mem_rvalid || tmo_cnt == TMO_LAST) begin
                    // A real response wins over a timeout landing in the same cycle.
                    state_d  = bus.mem_rvalid ? ARB_RESP : ARB_DRAIN;
                    rsp_err  = bus.mem_rvalid ? bus.mem_err : 1'b1;
                    rsp_data = bus.mem_rvalid ? bus.mem_rdata : '0;
                    if (owner_q == OWN_PTW) begin
                        ptw_rvalid_d = 1'b1;
                        ptw_fault_d  = rsp_err;
                        ptw_rdata_d  = rsp_data;
                    end else begin
                        lsu_rvalid_d = 1'b1;
                        lsu_err_d    = rsp_err;
                        lsu_rdata_d  = rsp_data;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt + TMO_W'(1);
                end
            end
            ARB_RESP:  state_d = ARB_IDLE;
            ARB_DRAIN: if (bus.mem_rvalid) state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_PTW;
            req_q        <= '0;
            mem_req_q    <= 1'b0;
            ptw_rvalid_q <= 1'b0;
            ptw_fault_q  <= 1'b0;
            ptw_rdata_q  <= '0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= '0;
            starve_cnt   <= '0;
            tmo_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            req_q        <= req_d;
            mem_req_q    <= mem_req_d;
            ptw_rvalid_q <= ptw_rvalid_d;
            ptw_fault_q  <= ptw_fault_d;
            ptw_rdata_q  <= ptw_rdata_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_err_q    <= lsu_err_d;
            lsu_rdata_q  <= lsu_rdata_d;
            starve_cnt   <= starve_cnt_d;
            tmo_cnt      <= tmo_cnt_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_we    = req_q.we;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_wstrb = req_q.wstrb;

    assign ptw_rvalid = ptw_rvalid_q;
    assign ptw_fault  = ptw_fault_q;
    assign ptw_rdata  = ptw_rdata_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign lsu_err    = lsu_err_q;
    assign lsu_rdata  = lsu_rdata_q;

endmodule
